// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter: bidirectional stepping, validated
// parallel load, one-hot phase decode and registered wrap / load-error pulses.
module johnson_counter_param #(
   parameter int WIDTH = 4,
   parameter int IDXW  = $clog2(2 * WIDTH)
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               enable,
   input  logic               dir,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   output logic [WIDTH-1:0]   count,
   output logic [IDXW-1:0]    state_idx,
   output logic [2*WIDTH-1:0] phase,
   output logic               wrap,
   output logic               load_err
);

   localparam int              PERIOD   = 2 * WIDTH;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PERIOD - 1);
   localparam logic [IDXW-1:0] PERIOD_M = IDXW'(PERIOD);

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_STEP,
      OP_LOAD,
      OP_REJECT
   } op_e;

   // Legal codes are thermometer patterns filled from bit 0, plus their complements.
   function automatic logic is_legal(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] low_ones;
      logic             ok;
      low_ones = '0;
      ok       = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         if (v == low_ones || v == ~low_ones) ok = 1'b1;
         low_ones = {low_ones[WIDTH-2:0], 1'b1};
      end
      return ok;
   endfunction

   // Popcount never exceeds WIDTH, which always fits in IDXW bits.
   function automatic logic [IDXW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [IDXW-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + IDXW'(v[i]);
      return n;
   endfunction

   op_e              op;
   logic [WIDTH-1:0] step_val;
   logic             step_wraps;
   logic [IDXW-1:0]  ones;

   // Position decode; modular IDXW arithmetic is exact because the result is < PERIOD.
   always_comb begin
      ones      = popcount(count);
      state_idx = count[WIDTH-1] ? (PERIOD_M - ones) : ones;
   end

   always_comb begin
      for (int i = 0; i < PERIOD; i++) phase[i] = (state_idx == IDXW'(i));
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      op = OP_HOLD;
      if (load)        op = is_legal(load_val) ? OP_LOAD : OP_REJECT;
      else if (enable) op = OP_STEP;
   end

   always_comb begin
      if (dir) begin
         step_val   = {~count[0], count[WIDTH-1:1]};
         step_wraps = (state_idx == '0);
      end else begin
         step_val   = {count[WIDTH-2:0], ~count[WIDTH-1]};
         step_wraps = (state_idx == LAST_IDX);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (clear) begin
         count    <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         wrap     <= (op == OP_STEP) && step_wraps;
         load_err <= (op == OP_REJECT);
         unique case (op)
            OP_LOAD:   count <= load_val;
            OP_REJECT: count <= '0;
            OP_STEP:   count <= step_val;
            default:   count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for johnson_counter_param: vector table on a 4-bit instance,
// hand-written period / load sequence on a 5-bit instance.
module tb_johnson_counter_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       c4_clear = 1'b0, c4_enable = 1'b0, c4_dir = 1'b0, c4_load = 1'b0;
   logic [3:0] c4_load_val = '0;
   logic [3:0] c4_count;
   logic [2:0] c4_idx;
   logic [7:0] c4_phase;
   logic       c4_wrap, c4_err;

   logic       c5_clear = 1'b0, c5_enable = 1'b0, c5_dir = 1'b0, c5_load = 1'b0;
   logic [4:0] c5_load_val = '0;
   logic [4:0] c5_count;
   logic [3:0] c5_idx;
   logic [9:0] c5_phase;
   logic       c5_wrap, c5_err;

   johnson_counter_param #(.WIDTH(4)) u_dut4 (
      .clk(clk), .clear(c4_clear), .enable(c4_enable), .dir(c4_dir),
      .load(c4_load), .load_val(c4_load_val), .count(c4_count),
      .state_idx(c4_idx), .phase(c4_phase), .wrap(c4_wrap), .load_err(c4_err)
   );

   johnson_counter_param #(.WIDTH(5)) u_dut5 (
      .clk(clk), .clear(c5_clear), .enable(c5_enable), .dir(c5_dir),
      .load(c5_load), .load_val(c5_load_val), .count(c5_count),
      .state_idx(c5_idx), .phase(c5_phase), .wrap(c5_wrap), .load_err(c5_err)
   );

   int tests  = 0;
   int failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic       clear, enable, dir, load;
      logic [3:0] load_val;
      logic [3:0] exp_count;
      int         exp_idx;
      logic       exp_wrap, exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic clr, input logic en,
                               input logic d, input logic ld, input logic [3:0] lv,
                               input logic [3:0] c, input int idx, input logic w,
                               input logic e);
      vec_t v;
      v.name = name; v.clear = clr; v.enable = en; v.dir = d; v.load = ld;
      v.load_val = lv; v.exp_count = c; v.exp_idx = idx; v.exp_wrap = w; v.exp_err = e;
      return v;
   endfunction

   initial begin
      logic [4:0] seq5 [10];
      logic [7:0] exp_ph4;
      logic [9:0] exp_ph5;
      int         wraps5;

      //                 name        clr en dir ld load_val  count    idx w  e
      vecs.push_back(mk("reset",     1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("fwd1",      0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0));
      vecs.push_back(mk("fwd2",      0, 1, 0, 0, 4'b0000, 4'b0011, 2, 0, 0));
      vecs.push_back(mk("fwd3",      0, 1, 0, 0, 4'b0000, 4'b0111, 3, 0, 0));
      vecs.push_back(mk("fwd4",      0, 1, 0, 0, 4'b0000, 4'b1111, 4, 0, 0));
      vecs.push_back(mk("fwd5",      0, 1, 0, 0, 4'b0000, 4'b1110, 5, 0, 0));
      vecs.push_back(mk("fwd6",      0, 1, 0, 0, 4'b0000, 4'b1100, 6, 0, 0));
      vecs.push_back(mk("fwd7",      0, 1, 0, 0, 4'b0000, 4'b1000, 7, 0, 0));
      vecs.push_back(mk("fwd8_wrap", 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 0));
      vecs.push_back(mk("fwd9",      0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0));
      vecs.push_back(mk("clear2",    1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("rev1_wrap", 0, 1, 1, 0, 4'b0000, 4'b1000, 7, 1, 0));
      vecs.push_back(mk("rev2",      0, 1, 1, 0, 4'b0000, 4'b1100, 6, 0, 0));
      vecs.push_back(mk("rev3",      0, 1, 1, 0, 4'b0000, 4'b1110, 5, 0, 0));
      vecs.push_back(mk("rev4",      0, 1, 1, 0, 4'b0000, 4'b1111, 4, 0, 0));
      vecs.push_back(mk("rev5",      0, 1, 1, 0, 4'b0000, 4'b0111, 3, 0, 0));
      vecs.push_back(mk("rev6",      0, 1, 1, 0, 4'b0000, 4'b0011, 2, 0, 0));
      vecs.push_back(mk("rev7",      0, 1, 1, 0, 4'b0000, 4'b0001, 1, 0, 0));
      vecs.push_back(mk("rev8",      0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("ld_1100",   0, 1, 0, 1, 4'b1100, 4'b1100, 6, 0, 0));
      vecs.push_back(mk("ld_step",   0, 1, 0, 0, 4'b0000, 4'b1000, 7, 0, 0));
      vecs.push_back(mk("bad_0101",  0, 0, 0, 1, 4'b0101, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("bad_clr",   0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("bad_1010",  0, 1, 0, 1, 4'b1010, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("bad_0110",  0, 0, 1, 1, 4'b0110, 4'b0000, 0, 0, 1));
      vecs.push_back(mk("bad_end",   0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("ld_0111",   0, 0, 0, 1, 4'b0111, 4'b0111, 3, 0, 0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk($sformatf("hold%0d", i), 0, 0, 1, 0, 4'b1010, 4'b0111, 3, 0, 0));
      vecs.push_back(mk("clr_pri",   1, 1, 0, 1, 4'b1111, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("ld_1110",   0, 0, 0, 1, 4'b1110, 4'b1110, 5, 0, 0));
      vecs.push_back(mk("clr_mid",   1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("ld_1000",   0, 0, 0, 1, 4'b1000, 4'b1000, 7, 0, 0));
      vecs.push_back(mk("wrap_ld",   0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 0));
      vecs.push_back(mk("ld_1000b",  0, 0, 0, 1, 4'b1000, 4'b1000, 7, 0, 0));
      vecs.push_back(mk("ld_0000",   0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("dir_f",     0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0));
      vecs.push_back(mk("dir_r",     0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
      vecs.push_back(mk("dir_r_w",   0, 1, 1, 0, 4'b0000, 4'b1000, 7, 1, 0));
      vecs.push_back(mk("dir_f_w",   0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 0));
      vecs.push_back(mk("ld_1111",   0, 0, 0, 1, 4'b1111, 4'b1111, 4, 0, 0));
      vecs.push_back(mk("ld_0001",   0, 1, 1, 1, 4'b0001, 4'b0001, 1, 0, 0));

      foreach (vecs[i]) begin
         @(negedge clk);
         c4_clear    = vecs[i].clear;
         c4_enable   = vecs[i].enable;
         c4_dir      = vecs[i].dir;
         c4_load     = vecs[i].load;
         c4_load_val = vecs[i].load_val;
         @(posedge clk);
         #1;
         exp_ph4 = 8'b1 << vecs[i].exp_idx;
         check({vecs[i].name, " count"}, 32'(c4_count), 32'(vecs[i].exp_count));
         check({vecs[i].name, " idx"},   32'(c4_idx),   32'(vecs[i].exp_idx));
         check({vecs[i].name, " phase"}, 32'(c4_phase), 32'(exp_ph4));
         check({vecs[i].name, " wrap"},  32'(c4_wrap),  32'(vecs[i].exp_wrap));
         check({vecs[i].name, " err"},   32'(c4_err),   32'(vecs[i].exp_err));
      end
      @(negedge clk);
      {c4_clear, c4_enable, c4_dir, c4_load} = 4'b0000;

      // WIDTH=5: full forward period from reset, then legal and illegal loads.
      seq5 = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
               5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
      c5_clear = 1'b1;
      @(posedge clk);
      #1;
      check("w5 reset count", 32'(c5_count), 32'd0);
      check("w5 reset phase", 32'(c5_phase), 32'd1);
      @(negedge clk);
      c5_clear  = 1'b0;
      c5_enable = 1'b1;
      wraps5    = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         exp_ph5 = 10'b1 << ((i + 1) % 10);
         check($sformatf("w5 step%0d count", i), 32'(c5_count), 32'(seq5[i]));
         check($sformatf("w5 step%0d idx", i),   32'(c5_idx),   32'((i + 1) % 10));
         check($sformatf("w5 step%0d phase", i), 32'(c5_phase), 32'(exp_ph5));
         if (c5_wrap === 1'b1) wraps5++;
      end
      check("w5 wrap count", 32'(wraps5), 32'd1);
      check("w5 wrap last", 32'(c5_wrap), 32'd1);

      @(negedge clk);
      c5_enable   = 1'b0;
      c5_load     = 1'b1;
      c5_load_val = 5'b11100;
      @(posedge clk);
      #1;
      check("w5 ld count", 32'(c5_count), 32'b11100);
      check("w5 ld idx",   32'(c5_idx),   32'd7);
      check("w5 ld phase", 32'(c5_phase), 32'h080);
      check("w5 ld err",   32'(c5_err),   32'd0);

      @(negedge clk);
      c5_load_val = 5'b10001;
      @(posedge clk);
      #1;
      check("w5 bad count", 32'(c5_count), 32'd0);
      check("w5 bad err",   32'(c5_err),   32'd1);
      check("w5 bad idx",   32'(c5_idx),   32'd0);

      @(negedge clk);
      c5_load = 1'b0;
      @(posedge clk);
      #1;
      check("w5 err pulse", 32'(c5_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/johnson_counter_param.md
# johnson_counter_param

Parametrised Johnson (twisted-ring) counter, the successor to the fixed 4-bit preset Johnson counter in the counters collection. It adds generic width, bidirectional stepping, a count enable, and a validated parallel load. Illegal load patterns are rejected. It also provides decoded phase outputs and a wrap pulse, so it can directly drive multi-phase sequencing logic elsewhere in the design.

## Interface
Parameters:
- WIDTH, 4, ring width in bits; legal range 2..16; sequence length is 2*WIDTH states
- IDXW, $clog2(2*WIDTH), width of state_idx (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- clear  in  1  reset, synchronous, active-high; one clock, reset is synchronous and active-high
- enable  in  1  step counter one state when high
- dir  in  1  0 = forward step, 1 = reverse step
- load  in  1  parallel load request
- load_val  in  WIDTH  value to load
- count  out  WIDTH  registered ring contents
- state_idx  out  IDXW  position of count in forward sequence, 0..2*WIDTH-1
- phase  out  2*WIDTH  one-hot decode of state_idx
- wrap  out  1  registered one-cycle pulse on sequence wrap
- load_err  out  1  registered one-cycle pulse when a load was rejected

## Operation
- Forward step: count <= {count[WIDTH-2:0], ~count[WIDTH-1]}.
  - WIDTH=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000, then back to 0000.
- Reverse step: count <= {~count[0], count[WIDTH-1:1]}. This walks the forward sequence backwards.
- Legal codes are the 2*WIDTH patterns with contiguous ones anchored at bit 0 or at bit WIDTH-1 (including all-zero and all-one).
- Priority per edge: clear > load > enable > hold.
- clear: count <= 0, wrap <= 0, load_err <= 0.
- load with legal load_val:
  - count <= load_val; load_err <= 0.
  - enable is ignored that cycle.
- load with illegal load_val:
  - count <= 0; load_err <= 1 for exactly one cycle.
  - Illegal patterns are never stored.
- enable, no load: step in direction dir.
- Neither enable nor load: hold count.
- state_idx decode (combinational from count):
  - count[WIDTH-1]==0: idx = popcount(count)
  - otherwise: idx = 2*WIDTH - popcount(count)
- phase[i] = (state_idx == i). Exactly one bit is set at all times.
- wrap rules:
  - Set to 1 on the edge where a forward step moves idx 2*WIDTH-1 -> 0.
  - Set to 1 on the edge where a reverse step moves idx 0 -> 2*WIDTH-1.
  - 0 on every other edge, including loads that land on idx 0.
- dir may change any cycle and takes effect on the next enabled step.

## Timing
- Reset values after a clear edge:
  - count=0, state_idx=0, phase=1 (bit 0), wrap=0, load_err=0.
- count, wrap and load_err update on the same rising edge as the controlling inputs. Latency is 1 cycle from inputs to count.
- state_idx and phase are combinational from count. They are valid in the same cycle as count, with no extra latency.
- wrap and load_err are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Sustained enable: one step per cycle; full period = 2*WIDTH cycles.
- Edge cases:
  - clear asserted together with load/enable: clear wins.
  - clear asserted mid-sequence returns to idx 0 on the next edge, with no wrap pulse.
  - load and enable together: the load wins and no step occurs.

## Test plan
- Reset and forward count (WIDTH=4):
  - Stimulus: clear=1 for 1 cycle, then enable=1, dir=0 for 9 cycles.
  - Response: count is 0000,0001,0011,0111,1111,1110,1100,1000,0000; wrap=1 only on the cycle count returns to 0000; phase walks bit 0..7.
- Reverse count (WIDTH=4):
  - Stimulus: from 0000, dir=1, enable=1.
  - Response: count is 1000,1100,1110,1111,0111,0011,0001,0000; wrap=1 on the first step (into 1000, idx 7).
- Legal load:
  - Stimulus: load=1, load_val=1100, with enable=1.
  - Response: next count=1100, state_idx=6, load_err=0; the following enabled forward step gives 1000.
- Illegal load:
  - Stimulus: load_val=0101.
  - Response: count=0000, load_err=1 for one cycle, state_idx=0.
- Hold and priority:
  - Stimulus: enable=0 for 5 cycles at 0111.
  - Response: count stays 0111.
  - Stimulus: assert clear and load (load_val=1111) together.
  - Response: count=0000.
- Width generality (WIDTH=5):
  - Stimulus: 10 enabled forward steps from reset.
  - Response: period of 10, wrap once; a load of 11100 gives state_idx=7.
